rv_plic_gateway_ctrl: RTL and testbench

- Per-target interrupt gateway and claim/complete sequencer. It sits in front of the PLIC priority-tree target.
- Converts raw synchronous interrupt sources (level or edge) into the pending vector `ip` consumed by the tree.
- Services claim requests using the tree's registered winning ID and retires sources on complete.
- Enforces one outstanding service per source.

---
 rtl/rv_plic_ctrl_pkg.sv | 27 ++
 rtl/rv_plic_gateway_slice.sv | 64 ++++++
 rtl/rv_plic_gateway_ctrl.sv | 85 ++++++++
 tb/tb_rv_plic_gateway_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_plic_ctrl_pkg.sv
// Shared types for the PLIC gateway: per-source state encoding and the ID decoder.
package rv_plic_ctrl_pkg;

   typedef enum logic [1:0] {
      GW_IDLE    = 2'd0,
      GW_PENDING = 2'd1,
      GW_ACTIVE  = 2'd2
   } gw_state_e;

   // Wide enough for any realistic source count; callers zero-extend their IDs into it.
   localparam int unsigned ID_MAX_W = 16;

   typedef struct packed {
      logic                valid;
      logic [ID_MAX_W-1:0] idx;
   } id_dec_t;

   // ID k+1 maps to source index k; ID 0 and IDs above n_source decode as invalid.
   function automatic id_dec_t id_to_idx(input logic [ID_MAX_W-1:0] id,
                                         input int unsigned         n_source);
      id_dec_t dec;
      dec.valid = (id != '0) && (id <= ID_MAX_W'(n_source));
      dec.idx   = id - ID_MAX_W'(1);
      return dec;
   endfunction

endpackage

// File: rtl/rv_plic_gateway_slice.sv
// One interrupt source: trigger qualification (level or rising edge) and the
// IDLE/PENDING/ACTIVE service FSM with registered ip/ia outputs.
module rv_plic_gateway_slice
   import rv_plic_ctrl_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic src_i,
   input  logic le_i,
   input  logic claim_hit_i,
   input  logic complete_hit_i,
   output logic ip_o,
   output logic ia_o
);

   gw_state_e state_q;
   logic      src_q;
   logic      set;

   // src_q resets low, so an edge source already high at reset release fires on the first clock.
   assign set = le_i ? (src_i & ~src_q) : src_i;

   // NOTE: all state here is updated with non-blocking assignments so every flop samples
   // pre-edge values; blocking assignments would make src_q/state ordering-dependent.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= GW_IDLE;
         src_q   <= 1'b0;
         ip_o    <= 1'b0;
         ia_o    <= 1'b0;
      end else begin
         src_q <= src_i;
         unique case (state_q)
            GW_IDLE: begin
               if (set) begin
                  state_q <= GW_PENDING;
                  ip_o    <= 1'b1;
               end
            end
            GW_PENDING: begin
               // Further triggers while pending or active are coalesced, never queued.
               if (claim_hit_i) begin
                  state_q <= GW_ACTIVE;
                  ip_o    <= 1'b0;
                  ia_o    <= 1'b1;
               end
            end
            GW_ACTIVE: begin
               // Completion returns to IDLE only; a still-high level source re-pends next cycle.
               if (complete_hit_i) begin
                  state_q <= GW_IDLE;
                  ia_o    <= 1'b0;
               end
            end
            default: begin
               state_q <= GW_IDLE;
               ip_o    <= 1'b0;
               ia_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/rv_plic_gateway_ctrl.sv
// Per-target PLIC gateway: N_SOURCE source slices plus claim/complete ID decode,
// the registered claim response, and the count of in-service sources.
module rv_plic_gateway_ctrl
   import rv_plic_ctrl_pkg::*;
#(
   parameter  int unsigned N_SOURCE = 32,
   localparam int unsigned SRCW     = $clog2(N_SOURCE + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_SOURCE-1:0] intr_src_i,
   input  logic [N_SOURCE-1:0] le_i,
   input  logic [SRCW-1:0]     irq_id_i,
   input  logic                claim_i,
   input  logic                complete_i,
   input  logic [SRCW-1:0]     complete_id_i,
   output logic [N_SOURCE-1:0] ip_o,
   output logic [N_SOURCE-1:0] ia_o,
   output logic                claim_valid_o,
   output logic [SRCW-1:0]     claim_id_o,
   output logic [SRCW-1:0]     active_cnt_o
);

   id_dec_t             claim_dec;
   id_dec_t             cmp_dec;
   logic [N_SOURCE-1:0] claim_sel;
   logic [N_SOURCE-1:0] cmp_sel;
   logic [N_SOURCE-1:0] claim_hit;
   logic [N_SOURCE-1:0] cmp_hit;
   logic [N_SOURCE-1:0] ip;
   logic [N_SOURCE-1:0] ia;
   logic                claim_ok;
   logic                cmp_ok;

   // NOTE: every signal assigned here gets a value on entry, so no path can leave one
   // unassigned and infer a latch.
   always_comb begin
      claim_dec = id_to_idx(ID_MAX_W'(irq_id_i), N_SOURCE);
      cmp_dec   = id_to_idx(ID_MAX_W'(complete_id_i), N_SOURCE);
      claim_sel = '0;
      cmp_sel   = '0;
      for (int k = 0; k < N_SOURCE; k++) begin
         claim_sel[k] = claim_dec.valid && (claim_dec.idx == ID_MAX_W'(k));
         cmp_sel[k]   = cmp_dec.valid   && (cmp_dec.idx   == ID_MAX_W'(k));
      end
      // Only a PENDING source can be claimed and only an ACTIVE one completed; stale,
      // zero or out-of-range IDs simply select nothing.
      claim_hit = claim_i    ? (claim_sel & ip) : '0;
      cmp_hit   = complete_i ? (cmp_sel   & ia) : '0;
      claim_ok  = |claim_hit;
      cmp_ok    = |cmp_hit;
   end

   for (genvar k = 0; k < N_SOURCE; k++) begin : g_slice
      rv_plic_gateway_slice u_slice (
         .clk_i          (clk_i),
         .rst_ni         (rst_ni),
         .src_i          (intr_src_i[k]),
         .le_i           (le_i[k]),
         .claim_hit_i    (claim_hit[k]),
         .complete_hit_i (cmp_hit[k]),
         .ip_o           (ip[k]),
         .ia_o           (ia[k])
      );
   end

   assign ip_o = ip;
   assign ia_o = ia;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         claim_valid_o <= 1'b0;
         claim_id_o    <= '0;
         active_cnt_o  <= '0;
      end else begin
         claim_valid_o <= claim_i;
         if (claim_i) begin
            claim_id_o <= claim_ok ? irq_id_i : '0;
         end
         // Claim and complete always hit different sources, so both may apply in one cycle.
         active_cnt_o <= active_cnt_o + SRCW'(claim_ok) - SRCW'(cmp_ok);
      end
   end

endmodule

// File: tb/tb_rv_plic_gateway_ctrl.sv
// Bench for rv_plic_gateway_ctrl: hand-derived vector table, reset sequence,
// then randomized traffic against a set-based reference model.
module tb_rv_plic_gateway_ctrl;

   localparam int NS = 32;
   localparam int W  = 6;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic [NS-1:0] intr_src_i = '0;
   logic [NS-1:0] le_i = '0;
   logic [W-1:0]  irq_id_i = '0;
   logic          claim_i = 1'b0;
   logic          complete_i = 1'b0;
   logic [W-1:0]  complete_id_i = '0;
   logic [NS-1:0] ip_o;
   logic [NS-1:0] ia_o;
   logic          claim_valid_o;
   logic [W-1:0]  claim_id_o;
   logic [W-1:0]  active_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   rv_plic_gateway_ctrl #(.N_SOURCE(NS)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .intr_src_i    (intr_src_i),
      .le_i          (le_i),
      .irq_id_i      (irq_id_i),
      .claim_i       (claim_i),
      .complete_i    (complete_i),
      .complete_id_i (complete_id_i),
      .ip_o          (ip_o),
      .ia_o          (ia_o),
      .claim_valid_o (claim_valid_o),
      .claim_id_o    (claim_id_o),
      .active_cnt_o  (active_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] src;
      logic        claim;
      logic [5:0]  irq;
      logic        cmp;
      logic [5:0]  cid;
      logic [31:0] e_ip;
      logic [31:0] e_ia;
      logic        e_cv;
      logic [5:0]  e_id;
      logic [5:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   // Reference model: explicit pending/active sets per source ID.
   bit          m_pend[NS];
   bit          m_act[NS];
   bit          m_prev[NS];
   bit          m_cv;
   int          m_id;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(logic [31:0] src, logic claim, logic [5:0] irq, logic cmp,
                               logic [5:0] cid, logic [31:0] e_ip, logic [31:0] e_ia,
                               logic e_cv, logic [5:0] e_id, logic [5:0] e_cnt);
      vec_t v;
      v.src = src; v.claim = claim; v.irq = irq; v.cmp = cmp; v.cid = cid;
      v.e_ip = e_ip; v.e_ia = e_ia; v.e_cv = e_cv; v.e_id = e_id; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic drive(input logic [31:0] src, input logic claim, input logic [5:0] irq,
                        input logic cmp, input logic [5:0] cid);
      intr_src_i    = src;
      claim_i       = claim;
      irq_id_i      = irq;
      complete_i    = cmp;
      complete_id_i = cid;
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_ip, input logic [31:0] e_ia,
                            input logic e_cv, input logic [5:0] e_id, input logic [5:0] e_cnt);
      check({tag, ".ip"},  ip_o, e_ip);
      check({tag, ".ia"},  ia_o, e_ia);
      check({tag, ".cv"},  32'(claim_valid_o), 32'(e_cv));
      check({tag, ".id"},  32'(claim_id_o), 32'(e_id));
      check({tag, ".cnt"}, 32'(active_cnt_o), 32'(e_cnt));
   endtask

   task automatic model_clear();
      for (int k = 0; k < NS; k++) begin
         m_pend[k] = 0; m_act[k] = 0; m_prev[k] = 0;
      end
      m_cv = 0;
      m_id = 0;
   endtask

   // Applies one clock of the service rules to the model using pre-edge state and inputs.
   task automatic model_step(input logic [31:0] src, input logic [31:0] le, input int irq,
                             input bit claim, input bit cmp, input int cid);
      bit claim_good;
      bit cmp_good;
      claim_good = claim && irq >= 1 && irq <= NS && m_pend[irq-1];
      cmp_good   = cmp && cid >= 1 && cid <= NS && m_act[cid-1];
      for (int k = 0; k < NS; k++) begin
         bit trig;
         trig = le[k] ? (src[k] && !m_prev[k]) : src[k];
         if (m_pend[k]) begin
            if (claim_good && irq == k + 1) begin m_pend[k] = 0; m_act[k] = 1; end
         end else if (m_act[k]) begin
            if (cmp_good && cid == k + 1) m_act[k] = 0;
         end else if (trig) begin
            m_pend[k] = 1;
         end
         m_prev[k] = src[k];
      end
      m_cv = claim;
      if (claim) m_id = claim_good ? irq : 0;
   endtask

   function automatic logic [31:0] pack(input bit a[NS]);
      logic [31:0] r = '0;
      for (int k = 0; k < NS; k++) r[k] = a[k];
      return r;
   endfunction

   function automatic int popcount(input bit a[NS]);
      int c = 0;
      for (int k = 0; k < NS; k++) c += int'(a[k]);
      return c;
   endfunction

   initial begin
      // Table (le: source 0 edge, everything else level); expectations are post-edge values.
      vecs.push_back(mk(32'h08, 0, 0, 0, 0,  32'h08, 32'h00, 0, 0, 0));
      vecs.push_back(mk(32'h08, 1, 4, 0, 0,  32'h00, 32'h08, 1, 4, 1));
      vecs.push_back(mk(32'h08, 0, 0, 0, 0,  32'h00, 32'h08, 0, 4, 1));
      vecs.push_back(mk(32'h08, 0, 0, 1, 4,  32'h00, 32'h00, 0, 4, 0));
      vecs.push_back(mk(32'h08, 0, 0, 0, 0,  32'h08, 32'h00, 0, 4, 0));
      vecs.push_back(mk(32'h01, 0, 0, 0, 0,  32'h09, 32'h00, 0, 4, 0));
      vecs.push_back(mk(32'h00, 0, 0, 0, 0,  32'h09, 32'h00, 0, 4, 0));
      vecs.push_back(mk(32'h01, 0, 0, 0, 0,  32'h09, 32'h00, 0, 4, 0));
      vecs.push_back(mk(32'h00, 1, 1, 0, 0,  32'h08, 32'h01, 1, 1, 1));
      vecs.push_back(mk(32'h01, 0, 0, 0, 0,  32'h08, 32'h01, 0, 1, 1));
      vecs.push_back(mk(32'h00, 0, 0, 0, 0,  32'h08, 32'h01, 0, 1, 1));
      vecs.push_back(mk(32'h01, 0, 0, 1, 1,  32'h08, 32'h00, 0, 1, 0));
      vecs.push_back(mk(32'h00, 0, 0, 0, 0,  32'h08, 32'h00, 0, 1, 0));
      vecs.push_back(mk(32'h00, 1, 0, 0, 0,  32'h08, 32'h00, 1, 0, 0));
      vecs.push_back(mk(32'h00, 1, 9, 0, 0,  32'h08, 32'h00, 1, 0, 0));
      vecs.push_back(mk(32'h00, 0, 0, 1, 0,  32'h08, 32'h00, 0, 0, 0));
      vecs.push_back(mk(32'h00, 0, 0, 1, 33, 32'h08, 32'h00, 0, 0, 0));
      vecs.push_back(mk(32'h00, 0, 0, 1, 5,  32'h08, 32'h00, 0, 0, 0));
      vecs.push_back(mk(32'h42, 0, 0, 0, 0,  32'h4A, 32'h00, 0, 0, 0));
      vecs.push_back(mk(32'h00, 1, 7, 0, 0,  32'h0A, 32'h40, 1, 7, 1));
      vecs.push_back(mk(32'h00, 1, 2, 1, 7,  32'h08, 32'h02, 1, 2, 1));
      vecs.push_back(mk(32'h00, 1, 4, 0, 0,  32'h00, 32'h0A, 1, 4, 2));
      vecs.push_back(mk(32'h00, 1, 4, 0, 0,  32'h00, 32'h0A, 1, 0, 2));
      vecs.push_back(mk(32'h20, 0, 0, 0, 0,  32'h20, 32'h0A, 0, 0, 2));
      vecs.push_back(mk(32'h20, 1, 6, 0, 0,  32'h00, 32'h2A, 1, 6, 3));

      le_i = 32'h1;
      #2;
      check_all("reset", '0, '0, 0, 0, 0);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].src, vecs[i].claim, vecs[i].irq, vecs[i].cmp, vecs[i].cid);
         @(posedge clk_i); #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_ip, vecs[i].e_ia, vecs[i].e_cv,
                   vecs[i].e_id, vecs[i].e_cnt);
      end

      // Asynchronous reset with three sources ACTIVE and a claim in flight.
      drive(32'h0, 1, 2, 0, 0);
      #2 rst_ni = 1'b0;
      #1;
      check_all("async_rst", '0, '0, 0, 0, 0);
      drive(32'h1, 0, 0, 0, 0);
      @(posedge clk_i); #3;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      check_all("rst_release_edge", 32'h1, '0, 0, 0, 0);

      // Randomized traffic against the model.
      rst_ni = 1'b0;
      drive('0, 0, 0, 0, 0);
      model_clear();
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      le_i = $urandom;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [31:0] src;
         int   irq, cid;
         bit   clm, cmp;
         int   pl[$];
         int   al[$];
         if (cyc % 500 == 250) le_i = $urandom;
         src = $urandom & $urandom & $urandom;
         for (int k = 0; k < NS; k++) begin
            if (m_pend[k]) pl.push_back(k + 1);
            if (m_act[k])  al.push_back(k + 1);
         end
         clm = ($urandom_range(99) < 35);
         cmp = ($urandom_range(99) < 35);
         if (pl.size() > 0 && $urandom_range(99) < 70) irq = pl[$urandom_range(pl.size() - 1)];
         else irq = $urandom_range(40);
         if (al.size() > 0 && $urandom_range(99) < 70) cid = al[$urandom_range(al.size() - 1)];
         else cid = $urandom_range(40);
         drive(src, clm, W'(irq), cmp, W'(cid));
         model_step(src, le_i, irq, clm, cmp, cid);
         @(posedge clk_i); #1;
         check_all("rand", pack(m_pend), pack(m_act), m_cv, W'(m_id), W'(popcount(m_act)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
